// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and helpers for the wait-state data memory:
//             FSM state encoding, byte-lane / offset-width helpers and the
//             address-error cause codes.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Request sequencer states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Address error causes. A range error takes precedence over misalignment.
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;

  // Number of byte lanes in a data word.
  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  // Width of the byte-offset field inside a word address.
  function automatic int offset_width(input int dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
//  Module   : sram_array
//  Purpose  : Single-port synchronous word array with per-byte write enable
//             and a registered read port. Contents are not reset.
//  Ports    : clk      - clock, rising edge
//             en_i     - access enable for this cycle
//             we_i     - 1 = write enabled lanes, 0 = read into rdata_o
//             be_i     - byte-lane write enables
//             addr_i   - word index
//             wdata_i  - write data
//             rdata_o  - read data, updated only by read accesses
//  Revision : 1.0  initial release
// ============================================================================
module sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  localparam int LANES     = DATA_WIDTH / 8,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [LANES-1:0]      be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int l = 0; l < LANES; l++) begin
          if (be_i[l]) begin
            mem_q[addr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_ws.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_ws
//  Purpose  : Data memory with valid/ready request handshake, byte-lane write
//             enables, a configurable number of wait states and base-window
//             range / alignment checking of every address.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous reset, active-low
//             req_valid  - request present
//             req_ready  - block can accept a request
//             req_we     - 1 = store, 0 = load
//             req_addr   - byte address
//             req_wdata  - store data
//             req_be     - byte-lane write enables
//             rsp_valid  - one-cycle response strobe
//             rsp_rdata  - load data; 0 on store or error
//             rsp_err    - address error, qualified by rsp_valid
//             busy       - request in flight
//             rd_count   - successful loads (DATA_MEMORY_PERF_CNT_EN only)
//             wr_count   - successful stores (DATA_MEMORY_PERF_CNT_EN only)
//  Options  : define DATA_MEMORY_PERF_CNT_EN to add the saturating counters.
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_ws
  import mem_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 9,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy
`ifdef DATA_MEMORY_PERF_CNT_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
`endif
);

  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int OFF_W = offset_width(DATA_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WS_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdy_en_q;     // holds req_ready low until first edge after reset
  logic                   lat_we_q;
  logic [31:0]            lat_addr_q;
  logic [DATA_WIDTH-1:0]  lat_wdata_q;
  logic [LANES-1:0]       lat_be_q;
  logic                   err_q;
  logic                   ld_ok_q;

  logic                   w_accept;
  logic                   w_in_idle;
  logic                   w_go_resp;
  logic                   w_cur_we;
  logic [31:0]            w_cur_addr;
  logic [DATA_WIDTH-1:0]  w_cur_wdata;
  logic [LANES-1:0]       w_cur_be;
  logic                   w_range_err;
  logic                   w_align_err;
  logic [1:0]             w_err_cause;
  logic                   w_err;
  logic [IDX_W-1:0]       w_idx;
  logic [DATA_WIDTH-1:0]  w_ram_rdata;

  assign w_in_idle = (state_q == IDLE);
  assign req_ready = w_in_idle & rdy_en_q;
  assign w_accept  = req_valid & req_ready;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array access happens on the edge that enters RESP. With zero wait
  // states that edge is the accept edge itself, so the live request inputs
  // are used while in IDLE and the latched copy otherwise.
  assign w_go_resp   = (state_d == RESP);
  assign w_cur_we    = w_in_idle ? req_we    : lat_we_q;
  assign w_cur_addr  = w_in_idle ? req_addr  : lat_addr_q;
  assign w_cur_wdata = w_in_idle ? req_wdata : lat_wdata_q;
  assign w_cur_be    = w_in_idle ? req_be    : lat_be_q;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_range_err = (w_cur_addr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]);

  generate
    if (OFF_W > 0) begin : g_align
      assign w_align_err = |w_cur_addr[OFF_W-1:0];
    end else begin : g_no_align
      assign w_align_err = 1'b0;
    end
  endgenerate

  always_comb begin
    w_err_cause = ERR_NONE;
    if (w_range_err) begin
      w_err_cause = ERR_RANGE;
    end else if (w_align_err) begin
      w_err_cause = ERR_ALIGN;
    end
  end

  assign w_err = (w_err_cause != ERR_NONE);
  assign w_idx = w_cur_addr[ADDR_WIDTH-1:OFF_W];

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (w_go_resp & ~w_err),
    .we_i    (w_cur_we),
    .be_i    (w_cur_be),
    .addr_i  (w_idx),
    .wdata_i (w_cur_wdata),
    .rdata_o (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      err_q       <= 1'b0;
      ld_ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (w_accept) begin
        lat_we_q    <= req_we;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_be_q    <= req_be;
      end
      if (w_go_resp) begin
        err_q   <= w_err;
        ld_ok_q <= ~w_cur_we & ~w_err;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response
  // --------------------------------------------------------------------------
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  // The array's read register is not reset, so gate it to zero unless this
  // is the response of a good load.
  assign rsp_rdata = (rsp_valid & ld_ok_q) ? w_ram_rdata : '0;
  assign busy      = ~w_in_idle;

`ifdef DATA_MEMORY_PERF_CNT_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (w_go_resp & ~w_err) begin
      if (w_cur_we) begin
        if (wr_cnt_q != '1) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end
      end else begin
        if (rd_cnt_q != '1) begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ws.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_ws
//  Purpose  : Self-checking bench for data_memory_ws. Instance 0 runs with
//             two wait states, instance 1 with none.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_memory_ws;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          WIN  = 512;
  localparam int          WS0  = 2;
  localparam int          WS1  = 0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0] req_be;
  wire  [1:0]      req_ready;
  wire  [1:0]      rsp_valid;
  wire  [1:0]      rsp_err;
  wire  [1:0]      busy;
  wire  [1:0][31:0] rsp_rdata;
`ifdef DATA_MEMORY_PERF_CNT_EN
  wire  [1:0][31:0] rd_count;
  wire  [1:0][31:0] wr_count;
`endif

  data_memory_ws #(.WAIT_STATES(WS0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0])
`ifdef DATA_MEMORY_PERF_CNT_EN
    , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
  );

  data_memory_ws #(.WAIT_STATES(WS1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1])
`ifdef DATA_MEMORY_PERF_CNT_EN
    , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [2][128];
  vec_t        tbl [19];
  vec_t        hold [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference behaviour: a flat word array indexed by byte offset / 4.
  task automatic ref_access(input int d, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rd, output logic er);
    logic [31:0] off;
    int          idx;
    off = a - BASE;
    er  = !((a >= BASE) && (off < WIN) && (a % 4 == 0));
    rd  = '0;
    if (!er) begin
      idx = int'(off / 4);
      if (we) begin
        for (int l = 0; l < 4; l++) begin
          if (be[l]) mdl[d][idx][8*l +: 8] = wd[8*l +: 8];
        end
      end else begin
        rd = mdl[d][idx];
      end
    end
  endtask

  // One complete request/response on instance d; called just after a negedge.
  task automatic xact(input int d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er);
    int n;
    int lat;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, req_ready[d]}, 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && d == 0) chk("busy_in_wait", {31'd0, busy[d]}, 32'd1);
    end while (rsp_valid[d] !== 1'b1 && lat < 40);
    chk("latency", lat, (d == 0) ? WS0 + 1 : WS1 + 1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, exp_rd, a, wd;
    logic        er, exp_er;
    logic [3:0]  be;
    bit          we;
    int          sel;

    tbl[0]  = '{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h1001_0004, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    tbl[4]  = '{1'b0, 32'h1001_0006, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[5]  = '{1'b0, 32'h1002_0000, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[6]  = '{1'b1, 32'h1001_0005, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    tbl[7]  = '{1'b1, 32'h1000_FFFC, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    tbl[8]  = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    tbl[9]  = '{1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    tbl[11] = '{1'b1, 32'h1001_0004, 32'h55AA_0000, 4'hC, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'h55AA_BEAA, 1'b0};
    tbl[13] = '{1'b1, 32'h1001_01FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tbl[14] = '{1'b0, 32'h1001_01FC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[15] = '{1'b0, 32'h1001_0200, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[16] = '{1'b1, 32'h1001_0204, 32'h9999_9999, 4'hF, 32'h0,         1'b1};
    tbl[17] = '{1'b0, 32'h1001_0004, 32'h0,         4'h0, 32'h55AA_BEAA, 1'b0};
    tbl[18] = '{1'b0, 32'h1001_0003, 32'h0,         4'h0, 32'h0,         1'b1};

    hold[0] = '{1'b1, 32'h1001_0010, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    hold[1] = '{1'b0, 32'h1001_0010, 32'h0,         4'h0, 32'h1122_3344, 1'b0};
    hold[2] = '{1'b1, 32'h1001_0010, 32'hAABB_CCDD, 4'h6, 32'h0,         1'b0};
    hold[3] = '{1'b0, 32'h1001_0010, 32'h0,         4'h0, 32'h11BB_CC44, 1'b0};

    rst       = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset values and the first-edge release of req_ready
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d),     {31'd0, req_ready[d]}, 32'd0);
      chk($sformatf("rst_rsp_valid%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("rst_rdata%0d", d),     rsp_rdata[d],          32'd0);
      chk($sformatf("rst_err%0d", d),       {31'd0, rsp_err[d]},   32'd0);
      chk($sformatf("rst_busy%0d", d),      {31'd0, busy[d]},      32'd0);
    end
    rst = 1'b1;
    #1 chk("ready_before_edge", {31'd0, req_ready[0]}, 32'd0);
    @(negedge clk);
    chk("ready_after_edge0", {31'd0, req_ready[0]}, 32'd1);
    chk("ready_after_edge1", {31'd0, req_ready[1]}, 32'd1);

    // Directed vectors on the two-wait-state instance
    for (int i = 0; i < 19; i++) begin
      xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
    end

    // Store aborted by reset while waiting must leave memory untouched
    xact(0, 1'b1, 32'h1001_0008, 32'h0BAD_F00D, 4'hF, rd, er);
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h1001_0008;
    req_wdata[0] = 32'hFFFF_FFFF;
    req_be[0]    = 4'hF;
    req_valid[0] = 1'b1;
    chk("abort_pre_ready", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy[0]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_rst_busy",  {31'd0, busy[0]},      32'd0);
    chk("abort_rst_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("abort_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`ifdef DATA_MEMORY_PERF_CNT_EN
    chk("abort_wr_count", wr_count[0], 32'd0);
    chk("abort_rd_count", rd_count[0], 32'd0);
`endif
    xact(0, 1'b0, 32'h1001_0008, 32'h0, 4'h0, rd, er);
    chk("abort_rdata", rd, 32'h0BAD_F00D);
    chk("abort_err", {31'd0, er}, 32'd0);
`ifdef DATA_MEMORY_PERF_CNT_EN
    chk("post_rd_count", rd_count[0], 32'd1);
    chk("post_wr_count", wr_count[0], 32'd0);
`endif

    // Zero wait states with req_valid held across four requests
    req_we[1]    = hold[0].we;
    req_addr[1]  = hold[0].addr;
    req_wdata[1] = hold[0].wdata;
    req_be[1]    = hold[0].be;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        chk($sformatf("hold%0d_ready", i), {31'd0, req_ready[1]}, 32'd1);
        chk($sformatf("hold%0d_idle", i),  {31'd0, rsp_valid[1]}, 32'd0);
      end else begin
        chk($sformatf("hold%0d_valid", i), {31'd0, rsp_valid[1]}, 32'd1);
        chk($sformatf("hold%0d_rdata", i), rsp_rdata[1], hold[i/2].exp_rd);
        chk($sformatf("hold%0d_err", i),   {31'd0, rsp_err[1]},   32'd0);
        chk($sformatf("hold%0d_busy", i),  {31'd0, req_ready[1]}, 32'd0);
        if (i / 2 + 1 < 4) begin
          req_we[1]    = hold[i/2+1].we;
          req_addr[1]  = hold[i/2+1].addr;
          req_wdata[1] = hold[i/2+1].wdata;
          req_be[1]    = hold[i/2+1].be;
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("hold_no_extra", {31'd0, rsp_valid[1]}, 32'd0);

    // Randomized traffic against the reference array
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 128; w++) begin
        a  = BASE + 32'(w * 4);
        wd = $urandom;
        ref_access(d, 1'b1, a, wd, 4'hF, exp_rd, exp_er);
        xact(d, 1'b1, a, wd, 4'hF, rd, er);
        chk("init_err", {31'd0, er}, {31'd0, exp_er});
      end
      for (int k = 0; k < ((d == 0) ? 60 : 150); k++) begin
        we  = 1'($urandom_range(0, 1));
        be  = 4'($urandom_range(0, 15));
        wd  = $urandom;
        sel = int'($urandom_range(0, 9));
        if (sel < 6)       a = BASE + 4 * $urandom_range(0, 127);
        else if (sel == 6) a = BASE + 4 * $urandom_range(0, 127) + $urandom_range(1, 3);
        else if (sel == 7) a = BASE + WIN + 4 * $urandom_range(0, 1023);
        else if (sel == 8) a = BASE - 4 * $urandom_range(1, 1024);
        else               a = $urandom;
        ref_access(d, we, a, wd, be, exp_rd, exp_er);
        xact(d, we, a, wd, be, rd, er);
        chk($sformatf("rnd%0d_%0d_rdata", d, k), rd, exp_rd);
        chk($sformatf("rnd%0d_%0d_err", d, k), {31'd0, er}, {31'd0, exp_er});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
Parametrised successor to the single-cycle data RAM used beside top_proc. It adds a valid/ready request handshake, byte-lane write enables and a configurable number of wait states. It also range-checks and alignment-checks every address against a base window. It sits between the processor load/store path and the data array, so the core can be verified against slow memories.

Parameters:
DATA_WIDTH, 32, word width in bits (multiple of 8)
ADDR_WIDTH, 9, byte-address bits decoded inside the window; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words
BASE_ADDR, 32'h10010000, window base; must be aligned to 2**ADDR_WIDTH
WAIT_STATES, 2, extra cycles between accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  DATA_WIDTH  store data
req_be  in  DATA_WIDTH/8  byte-lane write enables
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_WIDTH  load data; 0 on store or error
rsp_err  out  1  address error, qualified by rsp_valid
busy  out  1  request in flight

Behaviour:
- Reset (rst=0, async): FSM goes to IDLE and the wait counter clears.
  - Outputs during reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - req_ready goes to 1 on the first clk edge after reset deassertion.
  - Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: req_ready=1.
  - On a clk edge with req_valid & req_ready, latch we/addr/wdata/be.
  - Go to WAIT with count=WAIT_STATES-1 when WAIT_STATES>0; otherwise go straight to RESP.
- WAIT: req_ready=0, busy=1. Count decrements each cycle; at count==0 go to RESP.
- On entry to RESP, on the same edge:
  - Store: commit the write for enabled lanes only.
  - Load: register the read data.
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
- Latency: the response arrives WAIT_STATES+1 cycles after the accept edge. Throughput is one request per WAIT_STATES+2 cycles, because req_ready=0 in RESP.
- Address decode:
  - Word index = req_addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
  - Range error if req_addr[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH].
  - Misalign error if the low byte-offset bits are non-zero.
- On error: no write, rsp_rdata=0, rsp_err=1, same latency as a good access.
- req_be=0 on a store: legal no-op, rsp_err=0.
- Request inputs are ignored whenever req_ready=0; a held req_valid is accepted in the next IDLE.
- Reset mid-operation aborts the access. A store aborted before the RESP edge never writes.

Optional Feature:
DATA_MEMORY_PERF_CNT_EN: when defined, the block adds outputs rd_count[31:0] and wr_count[31:0].
- The counters increment at the RESP edge for successful loads and stores respectively.
- They saturate at 32'hFFFFFFFF and clear on reset.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_pkg holds: state enum (IDLE/WAIT/RESP), byte-lane count and offset-width localparam helpers, and the error-cause constants (ERR_NONE, ERR_RANGE, ERR_ALIGN) used internally and by the bench.
- Sub-module sram_array: single-port synchronous array with per-byte write enable and registered read; parameters DATA_WIDTH and depth.

Test Plan:
1. Reset (rst=0) then release, WAIT_STATES=2 -> req_ready=1 one edge after release.
2. Store 32'hDEADBEEF to 32'h10010004 with be=4'hF, then load the same address -> rsp_valid 3 cycles after each accept, rsp_rdata=32'hDEADBEEF, rsp_err=0.
3. Store 32'h000000AA with be=4'h1 to 32'h10010004, then load -> 32'hDEADBEAA.
4. Load from 32'h10010006 (misaligned) and from 32'h10020000 (out of range) -> rsp_err=1, rsp_rdata=0, memory unchanged.
5. WAIT_STATES=0 with req_valid held high for 4 requests -> accept every 2nd cycle, each response 1 cycle after its accept, no request dropped.
6. Store to 32'h10010008, assert rst in the WAIT state, release, then load 32'h10010008 -> prior value returned. With DATA_MEMORY_PERF_CNT_EN defined, wr_count=0 after the reset.
